// File: rtl/dbf_seq_pkg.sv
// rtl/dbf_seq_pkg.sv - shared state encoding and defaults for the DBF receive sequencer
// Purpose: FSM state type, default timing constants and a small width helper.
// Ports: none (package).
package dbf_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_FETCH,
        S_SETTLE,
        S_RX,
        S_DRAIN,
        S_GAP
    } state_t;

    localparam int DEF_ZONES     = 16;
    localparam int ZONE_WD       = $clog2(DEF_ZONES);
    localparam int DEF_TX_CYC    = 16;
    localparam int DEF_LUT_LAT   = 2;
    localparam int DEF_DRAIN_CYC = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dbf_rx_sequencer_timer.sv
// rtl/dbf_rx_sequencer_timer.sv - loadable down-counter with terminal-count flag
// Purpose: times every sequencer phase; a load of N-1 gives an N-cycle phase.
// Ports: clk, rst (sync active-high), load, load_val in; count, tc (count==0) out.
module dbf_seq_timer #(
    parameter int WD = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [WD-1:0] load_val,
    output logic [WD-1:0] count,
    output logic          tc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WD'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/dbf_rx_sequencer.sv
// rtl/dbf_rx_sequencer.sv - per-frame scan controller: TX window, LUT prefetch, zoned RX window
// Purpose: sequences TX -> FETCH -> SETTLE -> RX -> DRAIN -> GAP per scan line and
//          steps the delay-LUT address through the depth zones of each line.
// Ports: clk, rst_n (sync active-high), frame_go, abort, num_lines, zone_len, line_gap in;
//        tx_en, start, dbf_lut_addr, dbf_lut_we, line_idx, zone_idx, busy,
//        line_done, frame_done, cfg_err out (all registered).
module dbf_rx_sequencer
    import dbf_seq_pkg::*;
#(
    parameter int ADDR_WD   = 10,
    parameter int ZONES     = DEF_ZONES,
    parameter int ZLEN_WD   = 12,
    parameter int LINE_WD   = 8,
    parameter int TX_CYC    = DEF_TX_CYC,
    parameter int LUT_LAT   = DEF_LUT_LAT,
    parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_go,
    input  logic                       abort,
    input  logic [LINE_WD-1:0]         num_lines,
    input  logic [ZLEN_WD-1:0]         zone_len,
    input  logic [7:0]                 line_gap,
    output logic                       tx_en,
    output logic                       start,
    output logic [ADDR_WD-1:0]         dbf_lut_addr,
    output logic                       dbf_lut_we,
    output logic [LINE_WD-1:0]         line_idx,
    output logic [$clog2(ZONES)-1:0]   zone_idx,
    output logic                       busy,
    output logic                       line_done,
    output logic                       frame_done,
    output logic                       cfg_err
);

    localparam int ZW = $clog2(ZONES);
    localparam int TW = max_int(max_int(ZLEN_WD, 8),
                        max_int($clog2(TX_CYC + 1),
                        max_int($clog2(LUT_LAT + 1), $clog2(DRAIN_CYC + 1))));
    localparam logic [ZW-1:0] ZONE_LAST = ZW'(ZONES - 1);

    state_t             state;
    logic [LINE_WD-1:0] lines_q;
    logic [ZLEN_WD-1:0] zlen_q;
    logic [7:0]         gap_q;

    logic               tmr_ld;
    logic [TW-1:0]      tmr_ld_val;
    logic [TW-1:0]      tmr_count;
    logic               tmr_tc;

    logic               cfg_ok;
    logic               zone_last;
    logic               last_line;
    logic               line_end;

    assign cfg_ok    = (num_lines != '0) && (zone_len != '0);
    assign zone_last = (zone_idx == ZONE_LAST);
    assign last_line = (line_idx == lines_q - LINE_WD'(1));
    // Line ends when GAP expires, or straight out of DRAIN when the gap is zero.
    assign line_end  = tmr_tc && ((state == S_GAP) || (state == S_DRAIN && gap_q == '0));

    function automatic logic [ADDR_WD-1:0] lut_addr(input logic [LINE_WD-1:0] lidx, input int zsel);
        logic [31:0] full;
        full = 32'(lidx) * 32'(ZONES) + 32'(zsel);
        return full[ADDR_WD-1:0];
    endfunction

    // Timer reload for the phase being entered; the timer counts down to 0 otherwise.
    always_comb begin
        tmr_ld     = 1'b0;
        tmr_ld_val = '0;
        case (state)
            S_IDLE: begin
                if (frame_go && cfg_ok) begin
                    tmr_ld     = 1'b1;
                    tmr_ld_val = TW'(TX_CYC - 1);
                end
            end
            S_FETCH: begin
                tmr_ld     = 1'b1;
                tmr_ld_val = TW'(LUT_LAT - 1);
            end
            S_SETTLE, S_RX: begin
                if (tmr_tc) begin
                    tmr_ld     = 1'b1;
                    tmr_ld_val = (state == S_RX && zone_last) ? TW'(DRAIN_CYC - 1)
                                                              : TW'(zlen_q) - TW'(1);
                end
            end
            S_DRAIN: begin
                if (tmr_tc) begin
                    tmr_ld     = 1'b1;
                    tmr_ld_val = (gap_q != '0) ? TW'(gap_q) - TW'(1) : TW'(TX_CYC - 1);
                end
            end
            S_GAP: begin
                if (tmr_tc) begin
                    tmr_ld     = 1'b1;
                    tmr_ld_val = TW'(TX_CYC - 1);
                end
            end
            default: begin
                tmr_ld     = 1'b0;
                tmr_ld_val = '0;
            end
        endcase
    end

    dbf_seq_timer #(
        .WD(TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst_n),
        .load     (tmr_ld),
        .load_val (tmr_ld_val),
        .count    (tmr_count),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk) begin
        line_done  <= 1'b0;
        frame_done <= 1'b0;
        cfg_err    <= 1'b0;
        dbf_lut_we <= 1'b0;
        if (rst_n || abort) begin
            state        <= S_IDLE;
            tx_en        <= 1'b0;
            start        <= 1'b0;
            busy         <= 1'b0;
            dbf_lut_addr <= '0;
            line_idx     <= '0;
            zone_idx     <= '0;
            if (rst_n) begin
                lines_q <= '0;
                zlen_q  <= '0;
                gap_q   <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_go) begin
                        if (cfg_ok) begin
                            lines_q  <= num_lines;
                            zlen_q   <= zone_len;
                            gap_q    <= line_gap;
                            line_idx <= '0;
                            zone_idx <= '0;
                            state    <= S_TX;
                            tx_en    <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_TX: begin
                    if (tmr_tc) begin
                        state        <= S_FETCH;
                        tx_en        <= 1'b0;
                        dbf_lut_we   <= 1'b1;
                        dbf_lut_addr <= lut_addr(line_idx, 0);
                    end
                end
                S_FETCH: state <= S_SETTLE;
                S_SETTLE: begin
                    if (tmr_tc) begin
                        state <= S_RX;
                        start <= 1'b1;
                        // One-sample zones: the first RX cycle is already the last sample of zone 0.
                        if (zlen_q == ZLEN_WD'(1) && ZONES > 1) begin
                            dbf_lut_we   <= 1'b1;
                            dbf_lut_addr <= lut_addr(line_idx, 1);
                        end
                    end
                end
                S_RX: begin
                    if (tmr_tc) begin
                        if (zone_last) begin
                            state <= S_DRAIN;
                            start <= 1'b0;
                        end else begin
                            zone_idx <= zone_idx + ZW'(1);
                            if (zlen_q == ZLEN_WD'(1) && int'(zone_idx) + 1 < ZONES - 1) begin
                                dbf_lut_we   <= 1'b1;
                                dbf_lut_addr <= lut_addr(line_idx, int'(zone_idx) + 2);
                            end
                        end
                    end else if (tmr_count == TW'(1) && !zone_last) begin
                        // Strobe lands on the zone's final sample cycle.
                        dbf_lut_we   <= 1'b1;
                        dbf_lut_addr <= lut_addr(line_idx, int'(zone_idx) + 1);
                    end
                end
                S_DRAIN: begin
                    if (tmr_tc && gap_q != '0) begin
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                end
                default: state <= S_IDLE;
            endcase

            if (line_end) begin
                line_done <= 1'b1;
                zone_idx  <= '0;
                if (last_line) begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end else begin
                    line_idx <= line_idx + LINE_WD'(1);
                    state    <= S_TX;
                    tx_en    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dbf_rx_sequencer.sv
// tb/tb_dbf_rx_sequencer.sv - self-checking bench for dbf_rx_sequencer
module tb_dbf_rx_sequencer;

    localparam int AW   = 3;
    localparam int Z    = 4;
    localparam int TXC  = 4;
    localparam int LAT  = 2;
    localparam int DRN  = 3;
    localparam int MAXC = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_go;
    logic        abort;
    logic [7:0]  num_lines;
    logic [11:0] zone_len;
    logic [7:0]  line_gap;
    logic        tx_en;
    logic        start;
    logic [2:0]  dbf_lut_addr;
    logic        dbf_lut_we;
    logic [7:0]  line_idx;
    logic [1:0]  zone_idx;
    logic        busy;
    logic        line_done;
    logic        frame_done;
    logic        cfg_err;

    int n_pass  = 0;
    int n_total = 0;

    int m_tx[MAXC], m_start[MAXC], m_we[MAXC], m_addr[MAXC];
    int m_ld[MAXC], m_fd[MAXC], m_busy[MAXC], m_cfg[MAXC];

    typedef struct {
        int nl;
        int zl;
        int gap;
        int exp_ld0;
        int exp_fd;
    } vec_t;

    vec_t tbl[7];

    dbf_rx_sequencer #(
        .ADDR_WD(AW), .ZONES(Z), .ZLEN_WD(12), .LINE_WD(8),
        .TX_CYC(TXC), .LUT_LAT(LAT), .DRAIN_CYC(DRN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_go     (frame_go),
        .abort        (abort),
        .num_lines    (num_lines),
        .zone_len     (zone_len),
        .line_gap     (line_gap),
        .tx_en        (tx_en),
        .start        (start),
        .dbf_lut_addr (dbf_lut_addr),
        .dbf_lut_we   (dbf_lut_we),
        .line_idx     (line_idx),
        .zone_idx     (zone_idx),
        .busy         (busy),
        .line_done    (line_done),
        .frame_done   (frame_done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    // Expected waveform of one frame, cycle 0 being the cycle frame_go is sampled.
    function automatic void build_model(input int nl, input int zl, input int gap, output int last);
        int per, t, rx0;
        for (int c = 0; c < MAXC; c++) begin
            m_tx[c] = 0; m_start[c] = 0; m_we[c] = 0; m_addr[c] = 0;
            m_ld[c] = 0; m_fd[c] = 0; m_busy[c] = 0; m_cfg[c] = 0;
        end
        if (nl == 0 || zl == 0) begin
            m_cfg[1] = 1;
            last = 4;
            return;
        end
        per = TXC + 1 + LAT + Z * zl + DRN + gap;
        for (int l = 0; l < nl; l++) begin
            t = 1 + l * per;
            for (int k = 0; k < TXC; k++) m_tx[t + k] = 1;
            m_we[t + TXC]   = 1;
            m_addr[t + TXC] = (l * Z) % (1 << AW);
            rx0 = t + TXC + 1 + LAT;
            for (int k = 0; k < Z * zl; k++) m_start[rx0 + k] = 1;
            for (int zz = 1; zz < Z; zz++) begin
                m_we[rx0 + zz * zl - 1]   = 1;
                m_addr[rx0 + zz * zl - 1] = (l * Z + zz) % (1 << AW);
            end
            m_ld[t + per] = 1;
        end
        last = 1 + nl * per;
        m_fd[last] = 1;
        for (int c = 1; c < last; c++) m_busy[c] = 1;
    endfunction

    task automatic run_frame(input int nl, input int zl, input int gap, input bit noisy,
                             output int ld0_cyc, output int fd_cyc);
        int last, mm_tx, mm_st, mm_we, mm_addr, mm_ld, mm_fd, mm_busy, mm_cfg, ovl, n_ld, n_fd;
        string tag;
        tag = $sformatf("frame(nl=%0d,zl=%0d,gap=%0d)", nl, zl, gap);
        build_model(nl, zl, gap, last);
        mm_tx = 0; mm_st = 0; mm_we = 0; mm_addr = 0; mm_ld = 0; mm_fd = 0;
        mm_busy = 0; mm_cfg = 0; ovl = 0; n_ld = 0; n_fd = 0;
        ld0_cyc = -1; fd_cyc = -1;
        @(negedge clk);
        num_lines = 8'(nl); zone_len = 12'(zl); line_gap = 8'(gap); frame_go = 1'b1;
        for (int c = 1; c <= last + 2; c++) begin
            @(negedge clk);
            if (int'(tx_en) != m_tx[c])      mm_tx++;
            if (int'(start) != m_start[c])   mm_st++;
            if (int'(dbf_lut_we) != m_we[c]) mm_we++;
            if (m_we[c] == 1 && int'(dbf_lut_addr) != m_addr[c]) mm_addr++;
            if (int'(line_done) != m_ld[c])  mm_ld++;
            if (int'(frame_done) != m_fd[c]) mm_fd++;
            if (int'(busy) != m_busy[c])     mm_busy++;
            if (int'(cfg_err) != m_cfg[c])   mm_cfg++;
            if (tx_en && start) ovl++;
            if (line_done) begin
                n_ld++;
                if (ld0_cyc < 0) ld0_cyc = c;
            end
            if (frame_done) begin
                n_fd++;
                if (fd_cyc < 0) fd_cyc = c;
            end
            frame_go = 1'b0;
            if (noisy) begin
                num_lines = 8'($urandom_range(0, 255));
                zone_len  = 12'($urandom_range(0, 4095));
                line_gap  = 8'($urandom_range(0, 255));
                if (m_busy[c] == 1 && $urandom_range(0, 3) == 0) frame_go = 1'b1;
            end
        end
        frame_go = 1'b0;
        check({tag, " tx_en trace mismatches"}, mm_tx, 0);
        check({tag, " start trace mismatches"}, mm_st, 0);
        check({tag, " lut_we trace mismatches"}, mm_we, 0);
        check({tag, " lut_addr mismatches"}, mm_addr, 0);
        check({tag, " line_done trace mismatches"}, mm_ld, 0);
        check({tag, " frame_done trace mismatches"}, mm_fd, 0);
        check({tag, " busy trace mismatches"}, mm_busy, 0);
        check({tag, " cfg_err trace mismatches"}, mm_cfg, 0);
        check({tag, " tx_en&start overlap cycles"}, ovl, 0);
        check({tag, " line_done count"}, n_ld, (nl == 0 || zl == 0) ? 0 : nl);
        check({tag, " frame_done count"}, n_fd, (nl == 0 || zl == 0) ? 0 : 1);
    endtask

    function automatic int outputs_nonzero();
        return int'({tx_en, start, dbf_lut_addr, dbf_lut_we, line_idx, zone_idx,
                     busy, line_done, frame_done, cfg_err} != '0);
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ld0, fd, quiet;

        tbl[0] = '{2, 5, 2, 33, 65};
        tbl[1] = '{0, 5, 2, -1, -1};
        tbl[2] = '{3, 0, 1, -1, -1};
        tbl[3] = '{1, 1, 0, 15, 15};
        tbl[4] = '{3, 1, 0, 15, 43};
        tbl[5] = '{1, 3, 5, 28, 28};
        tbl[6] = '{4, 2, 1, 20, 77};

        rst_n = 1'b1; frame_go = 1'b0; abort = 1'b0;
        num_lines = '0; zone_len = '0; line_gap = '0;
        repeat (3) @(negedge clk);
        check("outputs nonzero during reset", outputs_nonzero(), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("outputs nonzero after reset", outputs_nonzero(), 0);

        foreach (tbl[i]) begin
            run_frame(tbl[i].nl, tbl[i].zl, tbl[i].gap, 1'b0, ld0, fd);
            check($sformatf("vec%0d first line_done cycle", i), ld0, tbl[i].exp_ld0);
            check($sformatf("vec%0d frame_done cycle", i), fd, tbl[i].exp_fd);
        end

        // Abort during zone 2 of line 0 (RX spans cycles 8..27, zone 2 is 18..22).
        @(negedge clk);
        num_lines = 8'd2; zone_len = 12'd5; line_gap = 8'd2; frame_go = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            frame_go = 1'b0;
        end
        check("pre-abort start", int'(start), 1);
        check("pre-abort zone_idx", int'(zone_idx), 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort start", int'(start), 0);
        check("abort busy", int'(busy), 0);
        check("abort line_idx", int'(line_idx), 0);
        check("abort zone_idx", int'(zone_idx), 0);
        check("abort outputs nonzero", outputs_nonzero(), 0);
        quiet = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (line_done || frame_done || busy || tx_en || start) quiet++;
        end
        check("post-abort activity cycles", quiet, 0);
        run_frame(2, 5, 2, 1'b0, ld0, fd);
        check("restart after abort frame_done cycle", fd, 65);

        // Abort and frame_go together: abort wins, no start and no cfg_err.
        @(negedge clk);
        num_lines = 8'd1; zone_len = 12'd2; line_gap = 8'd0; frame_go = 1'b1; abort = 1'b1;
        @(negedge clk);
        frame_go = 1'b0; abort = 1'b0;
        check("abort+go busy", int'(busy), 0);
        check("abort+go tx_en", int'(tx_en), 0);
        @(negedge clk);
        num_lines = 8'd0; frame_go = 1'b1; abort = 1'b1;
        @(negedge clk);
        frame_go = 1'b0; abort = 1'b0;
        check("abort+bad-go cfg_err", int'(cfg_err), 0);

        // Reset for one cycle in TX with frame_go held during the reset.
        @(negedge clk);
        num_lines = 8'd1; zone_len = 12'd2; line_gap = 8'd0; frame_go = 1'b1;
        @(negedge clk);
        frame_go = 1'b0;
        @(negedge clk);
        check("pre-reset tx_en", int'(tx_en), 1);
        rst_n = 1'b1; frame_go = 1'b1;
        @(negedge clk);
        rst_n = 1'b0; frame_go = 1'b0;
        check("mid-TX reset outputs nonzero", outputs_nonzero(), 0);
        quiet = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (busy || tx_en || start || dbf_lut_we) quiet++;
        end
        check("frame_go during reset ignored", quiet, 0);

        // Random legal frames with spurious frame_go and config churn while busy.
        for (int f = 0; f < 50; f++) begin
            run_frame($urandom_range(1, 4), $urandom_range(1, 6), $urandom_range(0, 4),
                      1'b1, ld0, fd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dbf_rx_sequencer.md
Name: dbf_rx_sequencer

Overview:
- Per-frame scan controller for the DBF channel array.
- For each scan line it sequences one transmit window (tx_en), a LUT prefetch, and a receive window (start).
- During receive it steps the coarse/fine delay LUT address through the depth zones of that line.
- One instance drives tx_en, start, dbf_lut_addr and dbf_lut_we in common to every dbf_ch* channel.

Parameters:
- ADDR_WD, 10: width of the delay-LUT address bus.
- ZONES, 16: number of depth zones per scan line.
- ZLEN_WD, 12: width of the zone-length configuration field.
- LINE_WD, 8: width of the line count and line index.
- TX_CYC, 16: tx_en high time in clk cycles (must be at least 1).
- LUT_LAT, 2: LUT read latency in cycles; the settle wait after the zone-0 fetch.
- DRAIN_CYC, 8: cycles that start is held low after receive, to let the channel pipelines flush.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: synchronous, active-high (a 1 sampled on the clk rising edge resets the block).
- frame_go  in  1  one-cycle pulse that starts a frame.
- abort  in  1  level; terminates the frame.
- num_lines  in  LINE_WD  number of lines per frame.
- zone_len  in  ZLEN_WD  samples per zone.
- line_gap  in  8  idle cycles between lines.
- tx_en  out  1  transmit window to the channels.
- start  out  1  receive window to the channels.
- dbf_lut_addr  out  ADDR_WD  delay-LUT address.
- dbf_lut_we  out  1  one-cycle LUT fetch strobe.
- line_idx  out  LINE_WD  current line.
- zone_idx  out  log2(ZONES)  current zone.
- busy  out  1  high in every state except IDLE.
- line_done  out  1  one-cycle pulse at the end of each line.
- frame_done  out  1  one-cycle pulse at the end of the frame.
- cfg_err  out  1  one-cycle pulse when frame_go is rejected.

Behaviour:
- All outputs are registered. The reset value of every output is 0, and the FSM resets to IDLE.
- Priority: rst_n > abort > frame_go.
- States: IDLE, TX, FETCH, SETTLE, RX, DRAIN, GAP.

IDLE:
- frame_go=1 with num_lines!=0 and zone_len!=0:
  - latch num_lines, zone_len and line_gap;
  - clear line_idx and zone_idx;
  - go to TX.
- frame_go=1 with num_lines=0 or zone_len=0: cfg_err pulses on the next cycle; the FSM stays in IDLE.
- frame_go while busy=1 is ignored, with no cfg_err.

TX:
- tx_en=1 for exactly TX_CYC cycles. tx_en first rises on the cycle after frame_go is sampled.
- Then go to FETCH.

FETCH (1 cycle):
- dbf_lut_we=1.
- dbf_lut_addr = line_idx*ZONES + 0, truncated to ADDR_WD, so it wraps modulo 2^ADDR_WD.

SETTLE:
- LUT_LAT cycles with tx_en=0 and start=0.
- Then go to RX.

RX:
- start=1 throughout.
- A sample counter runs 0..zone_len-1.
- On the last sample of a zone where zone_idx<ZONES-1:
  - zone_idx increments;
  - in the same cycle, dbf_lut_we=1 with dbf_lut_addr = line_idx*ZONES + (zone_idx+1).
- The new delay takes effect LUT_LAT cycles later. This lag is accepted.
- On the last sample of zone ZONES-1: go to DRAIN; start falls the next cycle.
- start is high for exactly ZONES*zone_len cycles per line.

DRAIN:
- DRAIN_CYC cycles with start=0.
- Then go to GAP.

GAP:
- line_gap cycles. line_gap=0 skips GAP entirely (0 cycles).
- On exit, line_done pulses.
  - If line_idx==num_lines-1: frame_done pulses in the same cycle and the FSM returns to IDLE.
  - Otherwise: line_idx increments, zone_idx clears, and the FSM goes to TX.

Other rules:
- tx_en and start are never high in the same cycle.
- dbf_lut_we is never high during TX.
- abort, or rst_n, mid-frame:
  - the FSM enters IDLE on the next edge;
  - all outputs go to 0, and line_idx and zone_idx clear;
  - no line_done or frame_done is produced.
- abort and frame_go in the same cycle: abort wins and the frame does not start.
- num_lines*ZONES > 2^ADDR_WD is a configuration error that is not checked; addresses wrap.
- Configuration inputs are sampled only at frame_go. Changing them mid-frame has no effect.

Decomposition:
- Shared package dbf_seq_pkg:
  - FSM state encoding;
  - localparam ZONE_WD = $clog2(ZONES);
  - default TX_CYC, LUT_LAT and DRAIN_CYC.
- One natural sub-module: dbf_seq_timer. It is a loadable down-counter with a terminal-count flag, reused for the TX, SETTLE, RX-sample, DRAIN and GAP timing.
- Address generation (multiply plus add, truncated to ADDR_WD) stays in the top level.

Test Plan:
All scenarios use ZONES=4, TX_CYC=4, LUT_LAT=2, DRAIN_CYC=3.

1. Two-line frame, basic sequencing.
   - Stimulus: num_lines=2, zone_len=5, line_gap=2, frame_go at cycle 0.
   - Required: tx_en high cycles 1-4; dbf_lut_we at cycle 5 with addr=0; start high cycles 8-27.
   - Required: dbf_lut_we with addr 1, 2 and 3 at cycles 12, 17 and 22.
   - Required: line_done at cycle 33; the second line uses addr 4-7; frame_done only at the end of line 1.
2. Rejected configuration.
   - Stimulus: frame_go with num_lines=0.
   - Required: cfg_err pulse for one cycle; busy stays 0; tx_en, start and dbf_lut_we all stay 0.
3. Abort mid-RX.
   - Stimulus: abort during zone 2 of line 0.
   - Required: next cycle, start=0, busy=0, line_idx=0; no line_done or frame_done.
   - Required: a subsequent frame_go restarts from addr 0.
4. Reset mid-TX.
   - Stimulus: rst_n=1 for one cycle during TX.
   - Required: all outputs read 0 on the following edge.
   - Required: frame_go issued during reset is ignored.
5. Address wrap with zero gap.
   - Stimulus: ADDR_WD=3, num_lines=3, zone_len=1, line_gap=0.
   - Required: line 2 addresses read 0, 1, 2, 3 (wrapped); zone_len=1 gives a dbf_lut_we on every RX cycle except the last.
   - Required: GAP is skipped, so TX follows DRAIN directly.
6. Protocol invariants.
   - Stimulus: 50 random legal frames, with frame_go also pulsed while busy.
   - Required: tx_en&start is never 1; extra frame_go pulses while busy have no effect; each frame produces exactly num_lines line_done pulses and one frame_done.
